// File: rtl/pc_seq_pkg.sv
// Shared encodings and defaults for the PC sequencer and the branch control block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pc_seq_pkg;

    // Next-PC source codes driven on selectmux by branch control.
    localparam logic [2:0] SEL_SEQ   = 3'b000;
    localparam logic [2:0] SEL_BR    = 3'b001;
    localparam logic [2:0] SEL_MV    = 3'b010;
    localparam logic [2:0] SEL_BALN  = 3'b011;
    localparam logic [2:0] SEL_BALRN = 3'b100;

    // Defaults for the sequencer parameters.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [4:0]  LINK_REG_DEFAULT = 5'd31;

    // One pending link-register write: destination index plus value.
    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } link_entry_t;

    // Instructions are word aligned, so the low two bits of any target are dropped.
    function automatic logic [31:0] align_target(input logic [31:0] target);
        return {target[31:2], 2'b00};
    endfunction

    // Codes 101..111 have no defined source.
    function automatic logic sel_is_legal(input logic [2:0] sel);
        return (sel <= SEL_BALRN);
    endfunction

    // Every legal code other than sequential moves the PC off the fall-through path.
    function automatic logic sel_is_jump(input logic [2:0] sel);
        return (sel != SEL_SEQ) && (sel <= SEL_BALRN);
    endfunction

endpackage

// File: rtl/pc_sequencer_link_buffer.sv
// Single-entry holding register for link-register writes toward the register file.
// Latency: entry visible one cycle after capture; retires on the edge where valid & ready.
// Backpressure: busy when a new request arrives while the held entry cannot drain.
module link_buffer
    import pc_seq_pkg::*;
#(
    parameter logic [4:0] DEST = LINK_REG_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        stall,
    input  logic        ready,
    input  logic [31:0] capture_data,
    output logic        valid,
    output logic [4:0]  dest,
    output logic [31:0] data,
    output logic        busy
);

    logic        valid_q;
    link_entry_t entry_q;
    logic        drain;
    logic        capture;

    // The slot is free for a new capture if it is empty or retiring this same edge.
    always_comb begin
        busy    = req & valid_q & ~ready;
        drain   = valid_q & ready;
        capture = req & ~stall & ~busy;
    end

    // Capture wins over drain so a back-to-back link write replaces the retiring one without a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else if (capture) begin
            valid_q      <= 1'b1;
            entry_q.dest <= DEST;
            entry_q.data <= capture_data;
        end else if (drain) begin
            // Payload is left as-is after retiring; only the valid flag drops.
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign dest  = entry_q.dest;
    assign data  = entry_q.data;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: picks next PC from five sources, emits link writes and redirect pulses.
// Latency: PC, redirect and link_valid update one cycle after their inputs are presented.
// Backpressure: stall or an undrainable link entry (busy) freezes the PC and link capture.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [4:0]  LINK_REG = LINK_REG_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  selectmux,
    input  logic        link_req,
    input  logic [31:0] target_br,
    input  logic [31:0] target_mv,
    input  logic [31:0] target_baln,
    input  logic [31:0] target_balrn,
    input  logic        link_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        link_valid,
    output logic [4:0]  link_dest,
    output logic [31:0] link_data,
    output logic        redirect,
    output logic        busy,
    output logic        sel_err
);

    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic        redirect_q;
    logic        sel_err_q;
    logic        link_busy;
    logic        hold;

    // Fall-through address; wraps modulo 2^32 with no error indication.
    assign pc_plus4 = pc_q + 32'd4;

    // The PC freezes for an external stall or while a second link write is waiting for room.
    assign hold = stall | link_busy;

    // Next-PC source mux; illegal codes fall back to the sequential address.
    always_comb begin
        next_pc = pc_plus4;
        case (selectmux)
            SEL_SEQ:   next_pc = pc_plus4;
            SEL_BR:    next_pc = align_target(target_br);
            SEL_MV:    next_pc = align_target(target_mv);
            SEL_BALN:  next_pc = align_target(target_baln);
            SEL_BALRN: next_pc = align_target(target_balrn);
            default:   next_pc = pc_plus4;
        endcase
    end

    // PC and redirect pulse; a held cycle never reports a redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
        end else if (hold) begin
            redirect_q <= 1'b0;
        end else begin
            pc_q       <= next_pc;
            redirect_q <= sel_is_jump(selectmux);
        end
    end

    // Illegal codes are flagged even on held cycles and the flag sticks until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else if (!sel_is_legal(selectmux)) begin
            sel_err_q <= 1'b1;
        end
    end

    // The link value is the fall-through address of the linking instruction.
    link_buffer #(
        .DEST (LINK_REG)
    ) u_link_buffer (
        .clk          (clk),
        .reset        (reset),
        .req          (link_req),
        .stall        (stall),
        .ready        (link_ready),
        .capture_data (pc_plus4),
        .valid        (link_valid),
        .dest         (link_dest),
        .data         (link_data),
        .busy         (link_busy)
    );

    assign pc       = pc_q;
    assign redirect = redirect_q;
    assign sel_err  = sel_err_q;
    assign busy     = link_busy;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: model-driven scoreboard plus directed value checks.
// Latency: expected state is pushed at stimulus time and compared one edge later.
// Backpressure: exercises stall, busy hold, simultaneous drain/capture and reset mid-handshake.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT inputs and outputs (RESET_PC = 0).
    logic        reset, stall, link_req, link_ready;
    logic [2:0]  selectmux;
    logic [31:0] target_br, target_mv, target_baln, target_balrn;
    logic [31:0] pc, pc_plus4, link_data;
    logic [4:0]  link_dest;
    logic        link_valid, redirect, busy, sel_err;

    // Second DUT with a reset PC at the top of the address space.
    logic        reset2, link_req2, link_ready2;
    logic [31:0] pc2, pc_plus4_2, link_data2;
    logic [4:0]  link_dest2;
    logic        link_valid2, redirect2, busy2, sel_err2;

    pc_sequencer u_dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .selectmux    (selectmux),
        .link_req     (link_req),
        .target_br    (target_br),
        .target_mv    (target_mv),
        .target_baln  (target_baln),
        .target_balrn (target_balrn),
        .link_ready   (link_ready),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .link_valid   (link_valid),
        .link_dest    (link_dest),
        .link_data    (link_data),
        .redirect     (redirect),
        .busy         (busy),
        .sel_err      (sel_err)
    );

    pc_sequencer #(
        .RESET_PC (32'hFFFF_FFFC)
    ) u_dut_wrap (
        .clk          (clk),
        .reset        (reset2),
        .stall        (1'b0),
        .selectmux    (SEL_SEQ),
        .link_req     (link_req2),
        .target_br    (32'h0),
        .target_mv    (32'h0),
        .target_baln  (32'h0),
        .target_balrn (32'h0),
        .link_ready   (link_ready2),
        .pc           (pc2),
        .pc_plus4     (pc_plus4_2),
        .link_valid   (link_valid2),
        .link_dest    (link_dest2),
        .link_data    (link_data2),
        .redirect     (redirect2),
        .busy         (busy2),
        .sel_err      (sel_err2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        redir;
        logic        lv;
        logic [31:0] ld;
        logic [4:0]  dest;
        logic        err;
    } exp_t;

    exp_t sb[$];

    // Reference state of the main DUT.
    logic [31:0] m_pc    = 32'h0;
    logic        m_redir = 1'b0;
    logic        m_lv    = 1'b0;
    logic [31:0] m_ld    = 32'h0;
    logic [4:0]  m_dest  = 5'd0;
    logic        m_err   = 1'b0;

    // One clock of stimulus: drive, check combinational outputs, predict, then compare after the edge.
    task automatic cyc(input logic rst, input logic st, input logic [2:0] sel,
                       input logic lr, input logic rdy, input logic [31:0] tgt);
        exp_t        e;
        exp_t        got;
        logic        m_busy, hold, cap, drn;
        logic [31:0] p4, nxt;
        @(negedge clk);
        reset        = rst;
        stall        = st;
        selectmux    = sel;
        link_req     = lr;
        link_ready   = rdy;
        target_br    = (sel == SEL_BR)    ? tgt : 32'hA5A5_1111;
        target_mv    = (sel == SEL_MV)    ? tgt : 32'hA5A5_2222;
        target_baln  = (sel == SEL_BALN)  ? tgt : 32'hA5A5_3333;
        target_balrn = (sel == SEL_BALRN) ? tgt : 32'hA5A5_4444;
        #1;
        p4     = m_pc + 32'd4;
        m_busy = lr & m_lv & ~rdy;
        hold   = st | m_busy;
        check_val("pc_plus4", pc_plus4, p4);
        check_val("busy", {31'b0, busy}, {31'b0, m_busy});
        case (sel)
            3'b001:  nxt = target_br    & 32'hFFFF_FFFC;
            3'b010:  nxt = target_mv    & 32'hFFFF_FFFC;
            3'b011:  nxt = target_baln  & 32'hFFFF_FFFC;
            3'b100:  nxt = target_balrn & 32'hFFFF_FFFC;
            default: nxt = p4;
        endcase
        if (rst) begin
            m_pc = 32'h0; m_redir = 1'b0; m_lv = 1'b0; m_ld = 32'h0; m_dest = 5'd0; m_err = 1'b0;
        end else begin
            if (sel > 3'd4) m_err = 1'b1;
            cap = ~hold & lr;
            drn = m_lv & rdy;
            if (cap) begin
                m_lv = 1'b1; m_ld = p4; m_dest = 5'd31;
            end else if (drn) begin
                m_lv = 1'b0;
            end
            if (!hold) begin
                m_pc    = nxt;
                m_redir = (sel >= 3'd1) && (sel <= 3'd4);
            end else begin
                m_redir = 1'b0;
            end
        end
        e.pc = m_pc; e.redir = m_redir; e.lv = m_lv; e.ld = m_ld; e.dest = m_dest; e.err = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_val("pc", pc, got.pc);
        check_val("redirect", {31'b0, redirect}, {31'b0, got.redir});
        check_val("link_valid", {31'b0, link_valid}, {31'b0, got.lv});
        check_val("link_data", link_data, got.ld);
        check_val("link_dest", {27'b0, link_dest}, {27'b0, got.dest});
        check_val("sel_err", {31'b0, sel_err}, {31'b0, got.err});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; selectmux = SEL_SEQ; link_req = 1'b0; link_ready = 1'b0;
        target_br = 32'h0; target_mv = 32'h0; target_baln = 32'h0; target_balrn = 32'h0;
        reset2 = 1'b1; link_req2 = 1'b0; link_ready2 = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state.
        cyc(1'b1, 1'b0, SEL_SEQ, 1'b0, 1'b0, 32'h0);
        check_val("rst_pc", pc, 32'h0);
        check_val("rst_lv", {31'b0, link_valid}, 32'h0);

        // Free-run sequential.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, SEL_SEQ, 1'b0, 1'b0, 32'h0);
            check_val("seq_pc", pc, 32'(4 * (i + 1)));
            check_val("seq_redir", {31'b0, redirect}, 32'h0);
        end

        // Branch with misaligned target, then fall-through.
        cyc(1'b0, 1'b0, SEL_BR, 1'b0, 1'b0, 32'h0000_0103);
        check_val("br_pc", pc, 32'h100);
        check_val("br_redir", {31'b0, redirect}, 32'h1);
        cyc(1'b0, 1'b0, SEL_SEQ, 1'b0, 1'b0, 32'h0);
        check_val("after_br_pc", pc, 32'h104);
        check_val("after_br_redir", {31'b0, redirect}, 32'h0);

        // Link capture, blocked second link, then simultaneous drain/capture.
        cyc(1'b0, 1'b0, SEL_BR, 1'b0, 1'b0, 32'h20);
        cyc(1'b0, 1'b0, SEL_SEQ, 1'b1, 1'b0, 32'h0);
        check_val("link1_data", link_data, 32'h24);
        check_val("link1_dest", {27'b0, link_dest}, 32'd31);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, SEL_SEQ, 1'b1, 1'b0, 32'h0);
        check_val("busy_pc", pc, 32'h24);
        check_val("busy_hold", {31'b0, busy}, 32'h1);
        cyc(1'b0, 1'b0, SEL_SEQ, 1'b1, 1'b1, 32'h0);
        check_val("link2_data", link_data, 32'h28);
        check_val("link2_valid", {31'b0, link_valid}, 32'h1);
        check_val("link2_pc", pc, 32'h28);
        cyc(1'b0, 1'b0, SEL_SEQ, 1'b0, 1'b1, 32'h0);
        check_val("drain_valid", {31'b0, link_valid}, 32'h0);
        check_val("drain_data_kept", link_data, 32'h28);

        // Stall holds PC, release takes the balrn target.
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, SEL_BALRN, 1'b0, 1'b0, 32'h400);
        check_val("stall_pc", pc, 32'h2C);
        check_val("stall_redir", {31'b0, redirect}, 32'h0);
        cyc(1'b0, 1'b0, SEL_BALRN, 1'b0, 1'b0, 32'h400);
        check_val("balrn_pc", pc, 32'h400);
        check_val("balrn_redir", {31'b0, redirect}, 32'h1);
        cyc(1'b0, 1'b0, SEL_MV, 1'b0, 1'b0, 32'h202);
        check_val("mv_pc", pc, 32'h200);
        cyc(1'b0, 1'b0, SEL_BALN, 1'b0, 1'b0, 32'h301);
        check_val("baln_pc", pc, 32'h300);

        // Stall lets a pending link drain but blocks a new capture.
        cyc(1'b0, 1'b0, SEL_SEQ, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, SEL_SEQ, 1'b0, 1'b1, 32'h0);
        check_val("stall_drain", {31'b0, link_valid}, 32'h0);
        cyc(1'b0, 1'b1, SEL_SEQ, 1'b1, 1'b0, 32'h0);
        check_val("stall_nocap", {31'b0, link_valid}, 32'h0);

        // Illegal selects: sequential step plus sticky error.
        cyc(1'b0, 1'b0, SEL_BR, 1'b0, 1'b0, 32'h30);
        cyc(1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 32'h0);
        check_val("ill_pc", pc, 32'h34);
        check_val("ill_err", {31'b0, sel_err}, 32'h1);
        cyc(1'b0, 1'b0, SEL_BR, 1'b0, 1'b0, 32'h500);
        cyc(1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 32'h0);
        check_val("ill_pc2", pc, 32'h508);

        // Wrap of the sequential address.
        cyc(1'b0, 1'b0, SEL_BR, 1'b0, 1'b0, 32'hFFFF_FFFF);
        check_val("top_pc", pc, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, SEL_SEQ, 1'b0, 1'b0, 32'h0);
        check_val("wrap_pc", pc, 32'h0);
        check_val("err_sticky", {31'b0, sel_err}, 32'h1);

        // Reset while a link entry is pending.
        cyc(1'b0, 1'b0, SEL_SEQ, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, SEL_SEQ, 1'b1, 1'b0, 32'h0);
        check_val("rst_mid_lv", {31'b0, link_valid}, 32'h0);
        check_val("rst_mid_err", {31'b0, sel_err}, 32'h0);

        // Illegal code during stall still sets the error.
        cyc(1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 32'h0);
        check_val("stall_ill_err", {31'b0, sel_err}, 32'h1);
        check_val("stall_ill_pc", pc, 32'h0);

        // Second instance: reset PC at the top of memory.
        check_val("w_rst_pc", pc2, 32'hFFFF_FFFC);
        @(negedge clk);
        reset2 = 1'b0; link_req2 = 1'b1; link_ready2 = 1'b0;
        #1;
        check_val("w_plus4", pc_plus4_2, 32'h0);
        check_val("w_busy0", {31'b0, busy2}, 32'h0);
        @(posedge clk);
        #1;
        check_val("w_pc", pc2, 32'h0);
        check_val("w_lv", {31'b0, link_valid2}, 32'h1);
        check_val("w_ld", link_data2, 32'h0);
        check_val("w_dest", {27'b0, link_dest2}, 32'd31);
        check_val("w_redir", {31'b0, redirect2}, 32'h0);
        check_val("w_err", {31'b0, sel_err2}, 32'h0);
        @(negedge clk);
        reset2 = 1'b1;
        #1;
        check_val("w_busy1", {31'b0, busy2}, 32'h1);
        @(posedge clk);
        #1;
        check_val("w_rst_lv", {31'b0, link_valid2}, 32'h0);
        check_val("w_rst_pc2", pc2, 32'hFFFF_FFFC);
        check_val("w_rst_ld", link_data2, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Consumes the 3-bit `selectmux` code and the `baln_out` / `bneal_out` qualifiers from the jump/branch control block.
- Owns the program counter. Each cycle it selects the next PC from one of the five target sources.
- Delivers link-register writebacks for baln/bneal/jalpc to the register file over a valid/ready handshake.
- Generates a one-cycle redirect pulse so the fetch path can squash the sequential fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- LINK_REG, 5'd31, destination register index for link writes.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  pipeline hold; freezes PC and link capture.
- selectmux  input  3  next-PC source code from branch control.
- link_req  input  1  current instruction writes a link (baln_out | bneal_out | jalpc, combined in datapath).
- target_br  input  32  branch/jump target for code 001.
- target_mv  input  32  bmv target for code 010.
- target_baln  input  32  baln target for code 011.
- target_balrn  input  32  balrn register target for code 100.
- link_ready  input  1  register file accepts the link write this cycle.
- pc  output  32  current PC.
- pc_plus4  output  32  pc + 4, combinational.
- link_valid  output  1  link write pending.
- link_dest  output  5  link destination register.
- link_data  output  32  link value (PC+4 of the linking instruction).
- redirect  output  1  registered pulse: last PC update was non-sequential.
- busy  output  1  combinational backpressure: link capture blocked.
- sel_err  output  1  sticky: illegal selectmux seen.

Behaviour:
- Reset (sync, `reset`=1 at edge):
  - pc=RESET_PC.
  - link_valid=0, link_dest=0, link_data=0.
  - redirect=0, sel_err=0.
  - Reset overrides every other input. A pending link is discarded mid-handshake.
- busy = link_req & link_valid & ~link_ready.
- hold = stall | busy.
- Next-PC mux:
  - 000 → pc+4.
  - 001 → target_br.
  - 010 → target_mv.
  - 011 → target_baln.
  - 100 → target_balrn.
  - 101/110/111 → pc+4, and sel_err is set to 1. sel_err stays set until reset.
- All targets have bits [1:0] forced to 0 before loading.
- pc+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000. No error is flagged on wrap.
- On an edge with hold=0: pc ← next-PC, and redirect ← (selectmux ∈ {001,010,011,100}).
- On an edge with hold=1: pc is unchanged and redirect ← 0.
- Illegal codes are evaluated (and set sel_err) even when hold=1.
- Link channel, single-entry buffer:
  - Capture: hold=0 and link_req=1 → link_valid←1, link_data←pc+4, link_dest←LINK_REG.
  - Drain: link_valid=1 and link_ready=1 at an edge → entry retires.
  - Drain and capture on the same edge → link_valid stays 1 and link_data takes the new value. No bubble, no loss.
  - Drain with no capture → link_valid←0. link_data/link_dest hold their last values.
  - A new link_req while the entry cannot drain raises busy. The PC then freezes until link_ready.
  - stall=1 blocks capture but does not block drain.
- Latency:
  - PC change is visible one cycle after selectmux is presented.
  - link_valid rises one cycle after the linking instruction.
- All outputs are registered except pc_plus4 and busy.

Decomposition:
- Shared package `pc_seq_pkg`:
  - selectmux encodings: SEL_SEQ=3'b000, SEL_BR=3'b001, SEL_MV=3'b010, SEL_BALN=3'b011, SEL_BALRN=3'b100.
  - RESET_PC default.
  - LINK_REG default.
- Branch control uses the same encoding constants.
- One sub-module, `link_buffer`: the single-entry valid/ready holding register (capture, drain, simultaneous case, busy).

Test Plan:
- Reset then free-run, selectmux=000, no stall → pc sequence 0x0, 0x4, 0x8, 0xC; redirect stays 0.
- At pc=0x10, selectmux=001, target_br=0x0000_0103 → next pc=0x0000_0100, redirect=1 for exactly one cycle. Then 000 → pc=0x104, redirect=0.
- link_req=1 at pc=0x20, link_ready=0 for 3 cycles, second link_req=1 at pc=0x24:
  - link_valid=1, link_data=0x24, link_dest=31.
  - busy=1 and pc held at 0x24 until link_ready=1.
  - On that edge link_data becomes 0x28 with link_valid still 1.
- stall=1 for 2 cycles with selectmux=100, target_balrn=0x400 → pc unchanged, redirect=0. On stall release, pc=0x400 and redirect=1.
- selectmux=111 at pc=0x30 → pc=0x34 and sel_err=1. sel_err stays 1 across later legal codes and clears only on reset.
- RESET_PC=32'hFFFF_FFFC, sequential step → pc=0x0. Reset asserted while link_valid=1 → link_valid=0 next edge and pc=RESET_PC.
